// File: rtl/io_mmio_ctrl.sv
// Memory-mapped IO block: UART RX/TX FIFOs, free-running cycle and retired-instruction
// counters, with a registered one-cycle load path back to the CPU.
module io_mmio_ctrl #(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [3:0] IO_BASE    = 4'h8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wbe,
  input  logic        re,
  input  logic        inst_retire,
  output logic [31:0] rdata,
  output logic        io_sel,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [7:0] OFF_STATUS = 8'h00;
  localparam logic [7:0] OFF_RXDATA = 8'h04;
  localparam logic [7:0] OFF_TXDATA = 8'h08;
  localparam logic [7:0] OFF_CYCLE  = 8'h10;
  localparam logic [7:0] OFF_INSTR  = 8'h14;
  localparam logic [7:0] OFF_CLEAR  = 8'h18;

  logic        hit, ld, st;
  logic [7:0]  off;

  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [AW:0] rx_wr, rx_rd, tx_wr, tx_rd;
  logic        rx_empty, rx_full, tx_empty, tx_full;
  logic        rx_push, rx_pop, tx_push, tx_pop;

  logic [31:0] cyc_cnt, inst_cnt;
  logic        cnt_clr;
  logic [31:0] rd_mux;

  logic        unused_bits;
  assign unused_bits = ^{addr[27:8], wdata[31:8]};

  // A load wins over a store presented in the same cycle.
  assign hit = (addr[31:28] == IO_BASE);
  assign off = addr[7:0];
  assign ld  = re && hit;
  assign st  = (|wbe) && !re && hit;

  assign rx_empty = (rx_wr == rx_rd);
  assign rx_full  = (rx_wr[AW] != rx_rd[AW]) && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);
  assign tx_empty = (tx_wr == tx_rd);
  assign tx_full  = (tx_wr[AW] != tx_rd[AW]) && (tx_wr[AW-1:0] == tx_rd[AW-1:0]);

  assign rx_ready = !rx_full;
  assign rx_push  = rx_valid && rx_ready;
  assign rx_pop   = ld && (off == OFF_RXDATA) && !rx_empty;

  assign tx_valid = !tx_empty;
  assign tx_data  = tx_mem[tx_rd[AW-1:0]];
  assign tx_pop   = tx_valid && tx_ready;
  // A full TX FIFO still takes a byte when the head leaves on the same edge.
  assign tx_push  = st && (off == OFF_TXDATA) && wbe[0] && (!tx_full || tx_pop);

  assign cnt_clr  = st && (off == OFF_CLEAR);

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr[AW-1:0]] <= rx_data;
    if (tx_push) tx_mem[tx_wr[AW-1:0]] <= wdata[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wr <= '0;
      rx_rd <= '0;
      tx_wr <= '0;
      tx_rd <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + (AW+1)'(1);
      if (rx_pop)  rx_rd <= rx_rd + (AW+1)'(1);
      if (tx_push) tx_wr <= tx_wr + (AW+1)'(1);
      if (tx_pop)  tx_rd <= tx_rd + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt  <= '0;
      inst_cnt <= '0;
    end else if (cnt_clr) begin
      cyc_cnt  <= '0;
      inst_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (inst_retire) inst_cnt <= inst_cnt + 32'd1;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_STATUS: rd_mux = {30'b0, !rx_empty, !tx_full};
      OFF_RXDATA: rd_mux = rx_empty ? '0 : {24'b0, rx_mem[rx_rd[AW-1:0]]};
      OFF_CYCLE:  rd_mux = cyc_cnt;
      OFF_INSTR:  rd_mux = inst_cnt;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata  <= '0;
      io_sel <= 1'b0;
    end else if (re) begin
      rdata  <= ld ? rd_mux : '0;
      io_sel <= ld;
    end
  end

endmodule

// File: doc/io_mmio_ctrl.md
IO_MMIO_CTRL -- requirements
Module: io_mmio_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, entries per UART FIFO; power of 2 and at least 2.
REQ-002 Parameter IO_BASE, default 4'h8, value of addr[31:28] that selects the IO region.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 addr  input  32  byte address of the CPU data access.
REQ-006 wdata  input  32  store data.
REQ-007 wbe  input  4  byte write enables; any bit set marks a store.
REQ-008 re  input  1  load request.
REQ-009 inst_retire  input  1  one instruction retired this cycle.
REQ-010 rdata  output  32  registered load data.
REQ-011 io_sel  output  1  registered: the previous-cycle access hit the IO region (drives the CPU writeback mux).
REQ-012 rx_data  input  8  byte from uart_receiver.
REQ-013 rx_valid  input  1  rx_data valid.
REQ-014 rx_ready  output  1  this block accepts rx_data.
REQ-015 tx_data  output  8  byte to uart_transmitter.
REQ-016 tx_valid  output  1  tx_data valid.
REQ-017 tx_ready  input  1  transmitter accepts tx_data.

Function
REQ-018 An access is an IO hit when addr[31:28]==IO_BASE; non-hit accesses change no state and leave rdata=0.
REQ-019 Address map, decoded on addr[7:0]:
- 0x00 status, read-only: bit0 = TX FIFO not full, bit1 = RX FIFO not empty, others 0.
- 0x04 RX data, read: {24'b0, head byte}.
- 0x08 TX data, write: wdata[7:0].
- 0x10 cycle counter, read.
- 0x14 instruction counter, read.
- 0x18 counter reset, write.
REQ-020 Load latency is 1 cycle: rdata and io_sel update on the edge that samples re; they hold until the next load.
REQ-021 Unmapped IO offsets read 0; stores to unmapped or read-only offsets are ignored.
REQ-022 RX FIFO: push when rx_valid && rx_ready; rx_ready = RX not full.
REQ-023 A load from 0x04 pops the RX FIFO when it is not empty.
REQ-024 A load from 0x04 with the RX FIFO empty returns 0 and changes no pointer.
REQ-025 TX FIFO: a store to 0x08 with wbe[0]=1 pushes wdata[7:0] when TX is not full; when TX is full the byte is dropped silently.
REQ-026 tx_valid = TX not empty; tx_data = TX head, combinational from FIFO storage; pop when tx_valid && tx_ready.
REQ-027 Each FIFO keeps FIFO_DEPTH entries with log2(FIFO_DEPTH)+1-bit pointers; pointers wrap modulo 2*FIFO_DEPTH; full/empty are derived from the pointer MSB and index compare.
REQ-028 A simultaneous push and pop on a full FIFO is legal, and occupancy stays full.
REQ-029 A simultaneous push and pop on an empty FIFO performs the push only.
REQ-030 The status register reflects FIFO state before the current-cycle push/pop.
REQ-031 Cycle counter: 32 bits, increments every cycle, wraps 0xFFFFFFFF->0.
REQ-032 Instruction counter: 32 bits, increments when inst_retire=1, wraps 0xFFFFFFFF->0.
REQ-033 Any store to 0x18 zeroes both counters on that edge; the clear takes priority over an increment in the same cycle.
REQ-034 A counter load returns the value before that cycle's increment.
REQ-035 re and a nonzero wbe in the same cycle is illegal; the load is served and the store ignored.

Reset
REQ-036 While rst=1, asynchronously: FIFO pointers=0, both counters=0, rdata=0, io_sel=0; therefore rx_ready=1 and tx_valid=0.
REQ-037 rst asserted mid-transfer discards all FIFO contents; FIFO storage arrays need no reset.
REQ-038 The first counter increment occurs on the first rising edge after rst deasserts.

Verification
REQ-039 Reset release, then load 0x80000000 -> next cycle rdata=0x1, io_sel=1.
REQ-040 Push rx bytes 0x41, 0x42 -> two loads of 0x80000004 return 0x41 then 0x42; a third load returns 0 and status reads 0x1.
REQ-041 tx_ready=0, store 9 bytes to 0x80000008 -> 8 queued, status bit0=0, 9th dropped; raise tx_ready -> bytes emerge in order over 8 cycles, then tx_valid=0.
REQ-042 inst_retire high 5 of 10 cycles -> load 0x80000014 returns 5; store 0x80000018 -> next cycle both counters read 0 with inst_retire=1 in the same cycle.
REQ-043 Force cycle counter to 0xFFFFFFFF -> one cycle later it reads 0x00000000.
REQ-044 Assert rst with 4 bytes in TX and 3 in RX -> tx_valid=0 and rx_ready=1 immediately, before the next clock edge.
